rr_onehot_arbiter: RTL and testbench

// - Upstream stage of the 4:2 Encoder: turns raw, possibly multi-hot request lines into a registered,

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 51 +++++
 rtl/rr_onehot_arbiter.sv | 95 +++++++++
 tb/tb_rr_onehot_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin one-hot arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Width of a counter or pointer able to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = int'($clog2(n));
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [N-1:0]  rot_pick;
  logic [PW-1:0] rot_idx;

  // Rotate right by ptr, take the lowest set bit, rotate the winner back left.
  always_comb begin
    int unsigned k;
    rot      = '0;
    rot_pick = '0;
    rot_idx  = '0;
    any      = 1'b0;
    pick     = '0;
    pick_idx = '0;
    k        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = i + ptr;
      if (k >= N) k = k - N;
      rot[PW'(i)] = req[PW'(k)];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && rot[PW'(i)]) begin
        rot_pick[PW'(i)] = 1'b1;
        rot_idx          = PW'(i);
        any              = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      k = i + ptr;
      if (k >= N) k = k - N;
      pick[PW'(k)] = rot_pick[PW'(i)];
    end
    k = rot_idx + ptr;
    if (k >= N) k = k - N;
    pick_idx = PW'(k);
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant, held until
// acknowledged, with a watchdog that force-releases an unacknowledged grant.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         gnt_ack,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam int unsigned PW = clog2_min1(N);
  localparam int unsigned CW = clog2_min1(MAX_HOLD + 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [CW-1:0] hold_cnt;

  logic [PW-1:0] ptr_sel;
  logic [PW-1:0] ptr_after;
  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          any;
  logic          release_now;

  // Pointer the next grant searches from: the stored pointer when idle,
  // one past the current winner when the current grant is being released.
  always_comb begin
    ptr_after   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    ptr_sel     = (state == ST_GRANT) ? ptr_after : ptr;
    release_now = (state == ST_GRANT) &&
                  (gnt_ack || (hold_cnt == CW'(MAX_HOLD - 1)));
  end

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (ptr_sel),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // Grant FSM with pointer, hold counter and all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt       <= pick;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            // Ack and watchdog share one release path; ack suppresses the pulse.
            ptr      <= ptr_after;
            hold_cnt <= '0;
            timeout  <= ~gnt_ack;
            if (any) begin
              gnt     <= pick;
              gnt_idx <= pick_idx;
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end else if (hold_cnt != CW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter with a per-cycle reference model.
module tb_rr_onehot_arbiter;

  localparam int N  = 4;
  localparam int MH = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '1;
  logic         gnt_ack = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         timeout;

  int tests = 0;
  int fails = 0;

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_ack   (gnt_ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the grant, where the search starts, how long it has waited.
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;

  function automatic int search(input logic [N-1:0] r, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_age   <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_valid) begin
        w = search(req, m_ptr);
        if (w >= 0) begin
          m_valid <= 1'b1;
          m_idx   <= w;
          m_age   <= 0;
        end
      end else if (gnt_ack || (m_age + 1 == MH)) begin
        m_to  <= !gnt_ack;
        m_ptr <= (m_idx + 1) % N;
        m_age <= 0;
        w = search(req, (m_idx + 1) % N);
        if (w >= 0) m_idx <= w;
        else        m_valid <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_valid) g[m_idx] = 1'b1;
    return g;
  endfunction

  function automatic int enc_y(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("model_gnt", 32'(gnt), 32'(model_gnt()));
    chk("model_valid", 32'(gnt_valid), 32'(m_valid));
    chk("model_timeout", 32'(timeout), 32'(m_to));
    chk("invariant", 32'(gnt_valid ? $onehot(gnt) : (gnt == '0)), 32'd1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req     = '0;
    gnt_ack = 1'b0;
    rst_n   = 1'b0;
    step(2);
    rst_n   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;

    // Reset held with every request high.
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(gnt_valid), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
    end
    rst_n = 1'b1;
    step(1);
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    chk("rst_first_y", 32'(enc_y(gnt)), 32'd0);
    gnt_ack = 1'b1; req = '0;
    step(1);
    gnt_ack = 1'b0;

    // Single request, ack three cycles later.
    req = 4'b0100;
    step(1);
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_valid", 32'(gnt_valid), 32'd1);
    step(2);
    gnt_ack = 1'b1; req = '0;
    step(1);
    chk("single_clr_gnt", 32'(gnt), 32'd0);
    chk("single_clr_valid", 32'(gnt_valid), 32'd0);
    gnt_ack = 1'b0;

    // Fairness with all requests and ack every cycle.
    do_reset();
    req = 4'b1111;
    step(1);
    chk("fair_gnt0", 32'(gnt), 32'b0001);
    gnt_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("fair_gnt", 32'(gnt), 32'(seq[i]));
      chk("fair_y", 32'(enc_y(gnt)), 32'((i + 1) % N));
      chk("fair_valid", 32'(gnt_valid), 32'd1);
    end
    gnt_ack = 1'b0; req = '0;
    step(3);
    chk("fair_frozen", 32'(gnt), 32'b0001);
    gnt_ack = 1'b1;
    step(1);
    chk("fair_idle", 32'(gnt_valid), 32'd0);
    gnt_ack = 1'b0;

    // Granted request drops; grant stays until ack.
    req = 4'b0010;
    step(1);
    chk("hold_gnt", 32'(gnt), 32'b0010);
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_frozen", 32'(gnt), 32'b0010);
    end
    gnt_ack = 1'b1;
    step(1);
    chk("hold_next", 32'(gnt), 32'b0100);
    req = '0;
    step(1);
    gnt_ack = 1'b0;

    // Watchdog: no ack, pulse on the 15th edge after the grant.
    req = 4'b0001;
    step(1);
    chk("wd_gnt", 32'(gnt), 32'b0001);
    for (int k = 1; k <= MH; k++) begin
      step(1);
      chk("wd_timeout", 32'(timeout), 32'(k == MH));
    end
    chk("wd_regrant", 32'(gnt), 32'b0001);
    chk("wd_regrant_valid", 32'(gnt_valid), 32'd1);
    for (int k = 1; k < MH; k++) begin
      step(1);
      chk("wd_quiet", 32'(timeout), 32'd0);
    end
    gnt_ack = 1'b1; req = '0;
    step(1);
    chk("wd_ack_wins", 32'(timeout), 32'd0);
    chk("wd_ack_valid", 32'(gnt_valid), 32'd0);
    gnt_ack = 1'b0;

    // Reset asserted mid-grant clears outputs at once.
    req = 4'b1000;
    step(1);
    chk("mid_gnt", 32'(gnt), 32'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_gnt", 32'(gnt), 32'd0);
    chk("mid_async_valid", 32'(gnt_valid), 32'd0);
    step(1);
    rst_n = 1'b1; req = 4'b1001;
    step(1);
    chk("mid_after", 32'(gnt), 32'b0001);
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
